// File: rtl/reg_share_arb_pkg.sv
// reg_share_arb_pkg: shared definitions for the TPU register-sharing arbiters.
//   state_t          - arbiter state encoding (ST_IDLE, ST_OWN)
//   pick_t           - result of a rotating-priority search (any / idx / one-hot)
//   rr_rotate_pick() - first set bit of mask searched from start, wrapping at n
package reg_share_arb_pkg;

    localparam int unsigned RR_MAXN = 8;
    localparam int unsigned RR_IDXW = 3;

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

    typedef struct packed {
        logic               any;
        logic [RR_IDXW-1:0] idx;
        logic [RR_MAXN-1:0] oh;
    } pick_t;

    // Search order is start, start+1, ..., n-1, 0, ..., start-1.
    function automatic pick_t rr_rotate_pick(input logic [RR_MAXN-1:0] mask,
                                             input logic [RR_IDXW-1:0] start,
                                             input int unsigned        n);
        pick_t              p;
        int unsigned        pos;
        logic [RR_IDXW-1:0] pos_i;
        p = '0;
        for (int unsigned k = 0; k < RR_MAXN; k++) begin
            if (k < n) begin
                pos   = (32'(start) + k) % n;
                pos_i = RR_IDXW'(pos);
                if (!p.any && mask[pos_i]) begin
                    p.any       = 1'b1;
                    p.idx       = pos_i;
                    p.oh[pos_i] = 1'b1;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/reg_share_arb_rr_pick.sv
// reg_share_arb_rr_pick: combinational rotating-priority picker.
//   mask  in  N   candidate requests
//   start in  SW  first index searched
//   oh    out N   one-hot pick (zero when mask is empty)
//   idx   out SW  index of the pick
//   any   out 1   mask had at least one bit set
module rr_pick
    import reg_share_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [SW-1:0] start,
    output logic [N-1:0]  oh,
    output logic [SW-1:0] idx,
    output logic          any
);

    pick_t              p;
    logic [RR_MAXN-1:0] mask8;

    always_comb begin
        mask8        = '0;
        mask8[N-1:0] = mask;
        p            = rr_rotate_pick(mask8, RR_IDXW'(start), N);
        oh           = p.oh[N-1:0];
        idx          = SW'(p.idx);
        any          = p.any;
    end

endmodule

// File: rtl/reg_share_arb.sv
// reg_share_arb: round-robin arbiter sharing one W-bit register among N requesters,
// with bounded bursts of up to MAX_BURST grants to one owner while others wait.
//   clk     in  1    rising-edge clock
//   reset_n in  1    asynchronous active-low reset
//   req     in  N    requests, held until granted
//   data    in  N*W  operands, requester i at [i*W +: W]
//   gnt     out N    one-hot combinational grant (transfer on req & gnt)
//   Y       out W    shared register
//   y_valid out 1    Y loaded on the previous edge
//   y_src   out SW   requester that loaded Y
module reg_share_arb
    import reg_share_arb_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned W         = 18,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N-1:0]           req,
    input  logic [N*W-1:0]         data,
    output logic [N-1:0]           gnt,
    output logic [W-1:0]           Y,
    output logic                   y_valid,
    output logic [$clog2(N)-1:0]   y_src
);

    localparam int unsigned SW = $clog2(N);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

    state_t        state, state_nx;
    logic [SW-1:0] own, own_nx, ptr, ptr_nx, own_inc, gidx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [N-1:0]  gnt_c, others, idle_oh, sw_oh;
    logic [SW-1:0] idle_idx, sw_idx;
    logic          idle_any, sw_any;
    logic [W-1:0]  dsel;

    assign own_inc = (own == SW'(N - 1)) ? '0 : own + 1'b1;
    assign others  = req & ~(N'(1) << own);

    rr_pick #(.N(N), .SW(SW)) u_pick_idle (
        .mask (req),
        .start(ptr),
        .oh   (idle_oh),
        .idx  (idle_idx),
        .any  (idle_any)
    );

    rr_pick #(.N(N), .SW(SW)) u_pick_switch (
        .mask (others),
        .start(own_inc),
        .oh   (sw_oh),
        .idx  (sw_idx),
        .any  (sw_any)
    );

    always_comb begin
        state_nx = state;
        own_nx   = own;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        gnt_c    = '0;
        gidx     = own;
        case (state)
            ST_IDLE: begin
                if (idle_any) begin
                    gnt_c    = idle_oh;
                    gidx     = idle_idx;
                    state_nx = ST_OWN;
                    own_nx   = idle_idx;
                    cnt_nx   = CW'(1);
                end
            end
            ST_OWN: begin
                if (req[own] && (cnt < MAXC || !sw_any)) begin
                    gnt_c = N'(1) << own;
                    if (cnt < MAXC) cnt_nx = cnt + 1'b1;
                end else if (sw_any) begin
                    gnt_c  = sw_oh;
                    gidx   = sw_idx;
                    own_nx = sw_idx;
                    cnt_nx = CW'(1);
                    ptr_nx = own_inc;
                end else begin
                    state_nx = ST_IDLE;
                    ptr_nx   = own_inc;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Gated so no grant is visible while reset is held, even though req may be high.
    assign gnt = reset_n ? gnt_c : '0;

    always_comb begin
        dsel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gidx == SW'(i)) dsel = data[i*W +: W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            own     <= '0;
            cnt     <= '0;
            ptr     <= '0;
            Y       <= '0;
            y_valid <= 1'b0;
            y_src   <= '0;
        end else begin
            state <= state_nx;
            own   <= own_nx;
            cnt   <= cnt_nx;
            ptr   <= ptr_nx;
            if (|gnt) begin
                Y       <= dsel;
                y_src   <= gidx;
                y_valid <= 1'b1;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_share_arb.sv
module tb_reg_share_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 18;
    localparam int unsigned MB = 4;

    localparam logic [W-1:0] D0 = 18'h000A0;
    localparam logic [W-1:0] D1 = 18'h011B1;
    localparam logic [W-1:0] D2 = 18'h022C2;
    localparam logic [W-1:0] D3 = 18'h033D3;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   gnt;
    logic [W-1:0]   Y;
    logic           y_valid;
    logic [1:0]     y_src;

    int n_cmp = 0;
    int n_err = 0;

    reg_share_arb #(.N(N), .W(W), .MAX_BURST(MB)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req),
        .data   (data),
        .gnt    (gnt),
        .Y      (Y),
        .y_valid(y_valid),
        .y_src  (y_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_data_const();
        data = {D3, D2, D1, D0};
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req     = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        set_data_const();
        reset_n = 1'b0;
        req     = 4'b1111;
        @(posedge clk);
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        n_cmp++; if (Y !== 18'h0) begin n_err++; $display("FAIL rst_Y: got %h want 0", Y); end
        n_cmp++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", y_valid); end
        n_cmp++; if (y_src !== 2'd0) begin n_err++; $display("FAIL rst_src: got %0d want 0", y_src); end
        reset_n = 1'b1;
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL first_gnt: got %b want 0001", gnt); end
        @(posedge clk);
        #1;
        n_cmp++; if (Y !== D0) begin n_err++; $display("FAIL first_Y: got %h want %h", Y, D0); end
        n_cmp++; if (y_src !== 2'd0) begin n_err++; $display("FAIL first_src: got %0d want 0", y_src); end
        n_cmp++; if (y_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", y_valid); end
    endtask

    task automatic test_burst();
        int unsigned  exp_idx [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        logic [W-1:0] exp_y;
        apply_reset();
        req = 4'b0011;
        for (int unsigned c = 0; c < 10; c++) begin
            for (int unsigned i = 0; i < N; i++) data[i*W +: W] = W'(c * 16 + i + 1);
            exp_y = W'(c * 16 + exp_idx[c] + 1);
            #1;
            n_cmp++; if (gnt !== (4'b0001 << exp_idx[c])) begin n_err++; $display("FAIL burst_gnt c=%0d: got %b want idx %0d", c, gnt, exp_idx[c]); end
            @(posedge clk);
            #1;
            n_cmp++; if (y_valid !== 1'b1) begin n_err++; $display("FAIL burst_valid c=%0d: got %b want 1", c, y_valid); end
            n_cmp++; if (y_src !== 2'(exp_idx[c])) begin n_err++; $display("FAIL burst_src c=%0d: got %0d want %0d", c, y_src, exp_idx[c]); end
            n_cmp++; if (Y !== exp_y) begin n_err++; $display("FAIL burst_Y c=%0d: got %h want %h", c, Y, exp_y); end
        end
    endtask

    task automatic test_sole();
        apply_reset();
        set_data_const();
        req = 4'b0100;
        for (int unsigned c = 0; c < 10; c++) begin
            #1;
            n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL sole_gnt c=%0d: got %b want 0100", c, gnt); end
            @(posedge clk);
            #1;
            n_cmp++; if (y_src !== 2'd2) begin n_err++; $display("FAIL sole_src c=%0d: got %0d want 2", c, y_src); end
        end
        n_cmp++; if (Y !== D2) begin n_err++; $display("FAIL sole_Y: got %h want %h", Y, D2); end
    endtask

    task automatic test_wrap_release();
        apply_reset();
        set_data_const();
        req = 4'b1000;
        #1;
        n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL wrap_own3: got %b want 1000", gnt); end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        // owner 3 at cnt=2 drops; 0 and 1 waiting
        req = 4'b0011;
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL wrap_gnt: got %b want 0001", gnt); end
        @(posedge clk);
        #1;
        n_cmp++; if (y_src !== 2'd0) begin n_err++; $display("FAIL wrap_src: got %0d want 0", y_src); end
        n_cmp++; if (Y !== D0) begin n_err++; $display("FAIL wrap_Y: got %h want %h", Y, D0); end
        req  = 4'b0000;
        data = {N*W{1'b1}};
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rel_gnt: got %b want 0000", gnt); end
        @(posedge clk);
        #1;
        n_cmp++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL rel_valid: got %b want 0", y_valid); end
        n_cmp++; if (Y !== D0) begin n_err++; $display("FAIL rel_Y_hold: got %h want %h", Y, D0); end
        n_cmp++; if (y_src !== 2'd0) begin n_err++; $display("FAIL rel_src_hold: got %0d want 0", y_src); end
        set_data_const();
        req = 4'b1111;
        #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL rel_ptr_gnt: got %b want 0010", gnt); end
        @(posedge clk);
        #1;
        n_cmp++; if (Y !== D1) begin n_err++; $display("FAIL rel_ptr_Y: got %h want %h", Y, D1); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_data_const();
        req = 4'b0100;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_cmp++; if (y_src !== 2'd2) begin n_err++; $display("FAIL mid_pre_src: got %0d want 2", y_src); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", y_valid); end
        n_cmp++; if (Y !== 18'h0) begin n_err++; $display("FAIL mid_Y: got %h want 0", Y); end
        n_cmp++; if (y_src !== 2'd0) begin n_err++; $display("FAIL mid_src: got %0d want 0", y_src); end
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL mid_gnt: got %b want 0000", gnt); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req     = 4'b1010;
        #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL mid_restart_gnt: got %b want 0010", gnt); end
        @(posedge clk);
        #1;
        n_cmp++; if (y_src !== 2'd1) begin n_err++; $display("FAIL mid_restart_src: got %0d want 1", y_src); end
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        data    = '0;
        test_reset();
        test_burst();
        test_sole();
        test_wrap_release();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_share_arb.md
# reg_share_arb

Round-robin arbiter that shares one W-bit pipeline register between N requesters in the TPU datapath. Each cycle it grants at most one requester, captures that requester's operand into the shared register, and tags the output with its source index. A bounded burst mode lets a requester keep the register for up to MAX_BURST consecutive cycles before it must yield to waiting requesters.

## Interface
- N, 4, number of requesters (2..8)
- W, 18, operand width in bits
- MAX_BURST, 4, maximum consecutive grants to one requester while others wait (≥1)
- SW, $clog2(N), width of source index (derived, local)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  N  request per requester; held high until granted
- data  in  N*W  operands; requester i occupies bits [i*W +: W]
- gnt  out  N  one-hot combinational grant; transfer occurs at the rising edge where req[i] & gnt[i]
- Y  out  W  shared register contents
- y_valid  out  1  Y was loaded on the previous edge
- y_src  out  SW  index of requester that loaded Y

## Operation
- States: IDLE (no owner), OWN (owner index `own`, burst count `cnt` from 1 to MAX_BURST).
- Pointer `ptr` gives the round-robin search start. Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1.
- IDLE:
  - If any req is high, grant the first requester in search order from ptr.
  - Go to OWN with own=that index and cnt=1.
  - Otherwise gnt=0 and stay in IDLE.
- OWN:
  - **Keep:** if req[own] is high and either cnt<MAX_BURST or no other req is high, keep the grant on own. cnt increments and saturates at MAX_BURST.
  - **Switch:** else if any other req is high, grant the first one in search order from own+1 (own itself excluded). Set own to that index, cnt=1, ptr=old own+1 mod N.
  - **Release:** else (no req high), gnt=0, go to IDLE, ptr=own+1 mod N.
- Wrap-around: own=N-1 gives a next search start of 0.
- On a transfer edge: Y ← data[g], y_src ← g, y_valid ← 1. With no grant: y_valid ← 0, and Y and y_src hold.
- gnt is never asserted for a requester whose req is low. gnt has at most one bit set.
- MAX_BURST=1 gives strict round-robin.

## Timing
- Reset, asynchronous and active-low:
  - Outputs: Y=0, y_valid=0, y_src=0. gnt=0 while reset_n is low.
  - Internal: state=IDLE, ptr=0, cnt=0.
- Reset mid-burst: the owner is dropped immediately. After release, arbitration restarts from ptr=0.
- Grant-to-output latency is 1 cycle: Y, y_valid and y_src are valid the cycle after the gnt&req edge.
- Sustained throughput is one transfer per cycle; there are no bubbles when switching owners.
- gnt is a combinational function of req and the registered state. It has no combinational path from data.
- A requester deasserting req in the same cycle it would be granted is not granted. The grant goes to the next requester in that same cycle.

## Structure
- Shared package holds the state encoding (ST_IDLE, ST_OWN) and a rotate-priority helper function (req, start) → one-hot/index. The function is reused by other TPU arbiters.
- One natural sub-module: `rr_pick` (combinational). Inputs are an N-bit mask and a start index; outputs are a one-hot grant, the index, and an any flag. It is used for both the IDLE search and the switch search.
- The output register is written behaviourally in this block, without per-bit instantiation.

## Test plan
- **Reset and idle:** reset_n low with all req=1 → gnt=0, Y=0, y_valid=0. After release with req=4'b1111 → gnt=4'b0001 in the first cycle; next cycle Y=data[0] and y_src=0.
- **Burst cap:** MAX_BURST=4, req=4'b0011 held. Gnt sequence is 0,0,0,0,1,1,1,1,0… (as indices). y_valid stays 1 every cycle after the first.
- **Sole requester:** only req[2]=1 for 10 cycles → gnt=4'b0100 on all 10 cycles (no forced yield), y_src=2 throughout.
- **Early drop and wrap:** own=3 mid-burst, req[3] drops, req[0] and req[1] are high → gnt=4'b0001 the same cycle, then ptr=0.
- **Release:** all req drop → gnt=0 the same cycle, y_valid=0 next cycle, Y holds its last value.
- **Reset mid-burst:** reset_n pulsed low at cnt=2 → outputs clear asynchronously. After release with req=4'b1010 → gnt=4'b0010.
